// File: rtl/sccb_pkg.sv
// sccb_pkg: shared definitions for the SCCB target.
//   - sccb_state_e     : protocol FSM states (RD_* only with SCCB_TARGET_READ_EN)
//   - SCCB_WRITE_BIT / SCCB_READ_BIT : R/W bit values in the ID byte
//   - BYTE_W / BITCNT_W : byte width and bit-counter width
package sccb_pkg;

  localparam int   BYTE_W         = 8;
  localparam int   BITCNT_W       = 3;
  localparam logic SCCB_WRITE_BIT = 1'b0;
  localparam logic SCCB_READ_BIT  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ACK_ID,
    ST_REG,
    ST_ACK_REG,
    ST_DATA,
    ST_ACK_DATA,
    ST_IGNORE
`ifdef SCCB_TARGET_READ_EN
    , ST_RD_DATA
    , ST_RD_ACK
`endif
  } sccb_state_e;

endpackage

// File: rtl/sccb_sync_edge.sv
// sccb_sync_edge: STAGES-deep synchronizer followed by a one-flop edge
// detector for one SCCB line.
//   clk, reset : system clock, async active-high reset
//   d_i        : raw pin
//   lvl_o      : synchronized level
//   rise_o     : synchronized level went 0->1 this cycle
//   fall_o     : synchronized level went 1->0 this cycle
// Flops reset to RST_VAL (bus idle level) so leaving reset with an idle
// bus creates no spurious edges.
module sccb_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o =  lvl_o & ~prev_q;
  assign fall_o = ~lvl_o &  prev_q;

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C responder with a 256x8 register file.
// Oversamples sioc/siod on clk, decodes ID / register / value write
// transactions and reports each committed write on wr_stb.
//   clk, reset        : system clock, async active-high reset
//   sioc              : SCCB clock from the initiator
//   siod              : SCCB data, open drain (driven 0 or z only)
//   wr_stb            : 1-cycle pulse per committed write
//   wr_addr, wr_data  : address / value of the last commit
//   rd_addr, rd_data  : host read port, 1-cycle registered read
//   busy              : high from START to STOP
// Optional feature macro SCCB_TARGET_READ_EN: accept the read ID
// (DEVICE_ID | 1) and shift regs[ptr] out MSB first.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc,
  inout  wire        siod,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy
);

  // DEVICE_ID already carries the write bit in its LSB.
  localparam logic [7:0] WR_ID = {DEVICE_ID[7:1], SCCB_WRITE_BIT};
`ifdef SCCB_TARGET_READ_EN
  localparam logic [7:0] RD_ID = {DEVICE_ID[7:1], SCCB_READ_BIT};
`endif

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  sccb_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl (
    .clk(clk), .reset(reset), .d_i(sioc),
    .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  sccb_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda (
    .clk(clk), .reset(reset), .d_i(siod),
    .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  wire start_det = sda_fall & scl_lvl;
  wire stop_det  = sda_rise & scl_lvl;

  sccb_state_e         state_q;
  logic [BITCNT_W-1:0] bitcnt_q;
  logic [BYTE_W-1:0]   shreg_q;
  logic [BYTE_W-1:0]   ptr_q;
  logic                sda_oe_q;
  logic                commit_q;
  logic                wr_stb_q;
  logic [BYTE_W-1:0]   wr_addr_q, wr_data_q;
  logic                busy_q;
  logic [BYTE_W-1:0]   rd_data_q;
`ifdef SCCB_TARGET_READ_EN
  logic                rnw_q;
  logic [BYTE_W-1:0]   tx_q;
`endif

  logic [BYTE_W-1:0] mem [256];

  // Byte as it stands once the current rising edge is shifted in.
  wire [BYTE_W-1:0] byte_d = {shreg_q[BYTE_W-2:0], sda_lvl};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      commit_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
      rnw_q     <= 1'b0;
      tx_q      <= '0;
`endif
    end else begin
      // The write lands one cycle after the byte completes; shreg_q and
      // ptr_q hold still in ACK_DATA, so they are safe to use here.
      commit_q <= 1'b0;
      wr_stb_q <= commit_q;
      if (commit_q) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= shreg_q;
      end

      // START/STOP need sda to move while scl is high, which we never do
      // ourselves, so releasing the line here cannot glitch the bus.
      if (start_det) begin
        state_q  <= ST_ID;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b1;
      end else if (stop_det) begin
        state_q  <= ST_IDLE;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_ID, ST_REG, ST_DATA: begin
            if (scl_rise) begin
              shreg_q  <= byte_d;
              bitcnt_q <= bitcnt_q + BITCNT_W'(1);
              if (bitcnt_q == '1) begin
                case (state_q)
                  ST_ID: begin
                    if (byte_d == WR_ID) begin
                      state_q <= ST_ACK_ID;
`ifdef SCCB_TARGET_READ_EN
                      rnw_q   <= 1'b0;
                    end else if (byte_d == RD_ID) begin
                      state_q <= ST_ACK_ID;
                      rnw_q   <= 1'b1;
`endif
                    end else begin
                      state_q <= ST_IGNORE;
                    end
                  end
                  ST_REG: begin
                    ptr_q   <= byte_d;
                    state_q <= ST_ACK_REG;
                  end
                  default: begin
                    commit_q <= 1'b1;
                    state_q  <= ST_ACK_DATA;
                  end
                endcase
              end
            end
          end

          // First falling edge pulls the line low, the next one (end of
          // the 9th clock) releases it and moves on.
          ST_ACK_ID, ST_ACK_REG, ST_ACK_DATA: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                case (state_q)
                  ST_ACK_ID: begin
`ifdef SCCB_TARGET_READ_EN
                    if (rnw_q) begin
                      // MSB goes out on the same edge that ends the ACK.
                      state_q  <= ST_RD_DATA;
                      tx_q     <= mem[ptr_q];
                      sda_oe_q <= ~mem[ptr_q][BYTE_W-1];
                    end else
`endif
                    state_q <= ST_REG;
                  end
                  ST_ACK_REG: state_q <= ST_DATA;
                  default:    state_q <= ST_IGNORE;
                endcase
              end
            end
          end

`ifdef SCCB_TARGET_READ_EN
          ST_RD_DATA: begin
            if (scl_fall) begin
              tx_q     <= {tx_q[BYTE_W-2:0], 1'b0};
              sda_oe_q <= ~tx_q[BYTE_W-2];
            end
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + BITCNT_W'(1);
              if (bitcnt_q == '1) state_q <= ST_RD_ACK;
            end
          end

          // Release for the initiator's ACK/NA; no burst either way.
          ST_RD_ACK: begin
            if (scl_fall) sda_oe_q <= 1'b0;
            if (scl_rise) state_q  <= ST_IGNORE;
          end
`endif

          default: ;
        endcase
      end
    end
  end

  // Register file: intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit_q) mem[ptr_q] <= shreg_q;
  end

  // Read-before-write on a same-cycle collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= mem[rd_addr];
  end

  assign siod    = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_data = rd_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed bench for sccb_target. Acts as SCCB initiator
// with a pull-up on siod; sioc period is 16 clk cycles.
module tb_sccb_target;

  localparam int Q    = 4;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset, sioc, m_drv;
  logic [7:0] rd_addr;
  wire        siod;
  logic       wr_stb, busy;
  logic [7:0] wr_addr, wr_data, rd_data;

  pullup (siod);
  assign siod = m_drv ? 1'b0 : 1'bz;

  sccb_target #(.DEVICE_ID(8'h42), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .sioc(sioc), .siod(siod),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, t_rise = 0, t_stb = 0;
  int stb_cnt = 0, low_cnt = 0;
  logic [7:0] stb_addr = 8'h00, stb_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe capture and "target pulled the line low" detector.
  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt++;
      stb_addr = wr_addr;
      stb_data = wr_data;
      t_stb    = cyc;
    end
    if (!m_drv && siod == 1'b0) low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Works from idle (sioc high) and as repeated START (sioc low).
  task automatic bus_start();
    m_drv = 1'b0; tick(Q);
    sioc  = 1'b1; tick(Q);
    m_drv = 1'b1; tick(Q);
    sioc  = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_drv = 1'b1; tick(Q);
    sioc  = 1'b1; tick(Q);
    m_drv = 1'b0; tick(2*Q);
  endtask

  task automatic send_bit(input logic b);
    m_drv = ~b; tick(Q);
    sioc  = 1'b1; t_rise = cyc; tick(2*Q);
    sioc  = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_drv = 1'b0; tick(Q);
    sioc  = 1'b1; tick(Q);
    ack   = (siod == 1'b0); tick(Q);
    sioc  = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b, output logic rel);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      m_drv = 1'b0; tick(Q);
      sioc  = 1'b1; tick(Q);
      r[i]  = siod; tick(Q);
      sioc  = 1'b0; tick(Q);
    end
    m_drv = ~nack; tick(Q);
    sioc  = 1'b1; tick(Q);
    rel   = siod; tick(Q);
    sioc  = 1'b0; tick(Q);
    b = r;
  endtask

  task automatic write3(input logic [7:0] id, input logic [7:0] ra, input logic [7:0] v,
                        output logic [2:0] acks);
    logic a;
    bus_start();
    send_byte(id, a); acks[2] = a;
    send_byte(ra, a); acks[1] = a;
    send_byte(v,  a); acks[0] = a;
    bus_stop();
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] v);
    rd_addr = a; tick(2);
    v = rd_data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] acks;
    logic       a0, a1, a2, a3, rel;
    logic [7:0] v;
    int         n0;

    reset = 1'b1; sioc = 1'b1; m_drv = 1'b0; rd_addr = 8'h00;
    tick(3);
    check("rst_busy",  busy,    0);
    check("rst_stb",   wr_stb,  0);
    check("rst_waddr", wr_addr, 0);
    check("rst_wdata", wr_data, 0);
    check("rst_rdata", rd_data, 0);
    check("rst_siod",  siod,    1);
    reset = 1'b0; tick(4);

    // Basic write 0x42 / 0x12 / 0x80.
    bus_start();
    send_byte(8'h42, a0);
    check("wr_busy", busy, 1);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    bus_stop();
    check("wr_acks", {a0, a1, a2}, 3'b111);
    check("wr_stb_cnt", stb_cnt, 1);
    check("wr_addr", stb_addr, 8'h12);
    check("wr_data", stb_data, 8'h80);
    check("wr_stb_lat", t_stb - t_rise, SYNC + 2);
    check("wr_busy_idle", busy, 0);
    host_read(8'h12, v);
    check("wr_rd", v, 8'h80);

    // Wrong ID: never pulled low, no write.
    low_cnt = 0; n0 = stb_cnt;
    write3(8'h60, 8'h12, 8'h55, acks);
    check("wid_acks", acks, 3'b000);
    check("wid_low", low_cnt, 0);
    check("wid_stb", stb_cnt, n0);
    host_read(8'h12, v);
    check("wid_rd", v, 8'h80);

    // Repeated START: 0x3A keeps its prior value.
    write3(8'h42, 8'h3A, 8'h11, acks);
    n0 = stb_cnt;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h3A, a1);
    bus_start();
    send_byte(8'h42, a2);
    send_byte(8'h40, a3);
    send_byte(8'hD0, a0);
    bus_stop();
    check("rs_acks", {a1, a2, a3, a0}, 4'b1111);
    check("rs_stb", stb_cnt, n0 + 1);
    check("rs_addr", stb_addr, 8'h40);
    check("rs_data", stb_data, 8'hD0);
    host_read(8'h3A, v);
    check("rs_rd3a", v, 8'h11);
    host_read(8'h40, v);
    check("rs_rd40", v, 8'hD0);

    // Reset during the 5th DATA bit (sioc high, line released).
    n0 = stb_cnt;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h12, a1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    m_drv = 1'b0; tick(Q);
    sioc  = 1'b1; tick(Q);
    reset = 1'b1; tick(2);
    check("mrst_siod", siod, 1);
    check("mrst_busy", busy, 0);
    check("mrst_stb", wr_stb, 0);
    reset = 1'b0; tick(2*Q);
    check("mrst_nowr", stb_cnt, n0);
    write3(8'h42, 8'h12, 8'h5A, acks);
    check("mrst_acks", acks, 3'b111);
    check("mrst_stb2", stb_cnt, n0 + 1);
    host_read(8'h12, v);
    check("mrst_rd", v, 8'h5A);

    // Extra byte: no ACK, no second write, no auto-increment.
    n0 = stb_cnt;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h12, a1);
    send_byte(8'h01, a2);
    send_byte(8'h02, a3);
    bus_stop();
    check("xb_acks", {a0, a1, a2, a3}, 4'b1110);
    check("xb_stb", stb_cnt, n0 + 1);
    check("xb_data", stb_data, 8'h01);
    host_read(8'h12, v);
    check("xb_rd", v, 8'h01);

`ifdef SCCB_TARGET_READ_EN
    write3(8'h42, 8'h0A, 8'h76, acks);
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1);
    bus_stop();
    bus_start();
    send_byte(8'h43, a2);
    recv_byte(1'b1, v, rel);
    bus_stop();
    check("rd_acks", {a0, a1, a2}, 3'b111);
    check("rd_byte", v, 8'h76);
    check("rd_na_rel", rel, 1);
    check("rd_idle", siod, 1);
`else
    low_cnt = 0;
    bus_start();
    send_byte(8'h43, a0);
    bus_stop();
    check("rdid_nack", a0, 0);
    check("rdid_low", low_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB/I2C target (responder) for the camera configuration bus: the camera-side end of the link whose initiator the OV7670 controller implements. It oversamples `sioc`/`siod` on the system clock, decodes 3-phase write transactions (device ID, register address, value) into an internal 256×8 register file and reports every committed write on a strobe port. It serves as a synthesizable camera stand-in for loopback bring-up and as the responder in controller benches.

## Interface
- `DEVICE_ID`, 8'h42: 7-bit address plus write bit accepted as the write ID. The read ID is `DEVICE_ID | 1`.
- `SYNC_STAGES`, 2: synchronizer depth on `sioc`/`siod`, minimum 2.
- `clk` in 1: system clock, at least 8× the `sioc` frequency.
- `reset` in 1: asynchronous, active-high.
- `sioc` in 1: SCCB clock from the initiator.
- `siod` inout 1: SCCB data. Open-drain: driven 0 or `z`, never 1.
- `wr_stb` out 1: one-cycle pulse when a register write commits.
- `wr_addr` out 8: register address of the last commit.
- `wr_data` out 8: value of the last commit.
- `rd_addr` in 8: host-side register file read address.
- `rd_data` out 8: registered read of `regs[rd_addr]`, 1-cycle latency.
- `busy` out 1: high from START detect to STOP detect.

## Operation
- **Input conditioning:** `sioc`/`siod` pass through `SYNC_STAGES` flops, then a 1-flop edge detector. All decisions use the synchronized values.
- **START:** `siod` falls while `sioc` is high. Accepted in any state, including repeated start. Next state is ID and the bit counter clears.
- **STOP:** `siod` rises while `sioc` is high. From any state, go to IDLE and release `siod`.
- **Bit reception:** bits are sampled on `sioc` rising edges, MSB first. A byte completes on its 8th rising edge.
- **ACK:** on the `sioc` falling edge after a completed accepted byte, drive `siod` low. Release it on the next falling edge (the end of the 9th clock).
- **States:** IDLE, ID, ACK_ID, REG, ACK_REG, DATA, ACK_DATA, IGNORE, plus RD_DATA and RD_ACK with the macro.
- **ID byte:**
  - Equal to `DEVICE_ID`: ACK, then REG.
  - Otherwise: no ACK, then IGNORE until START or STOP.
- **REG byte:** load the address pointer, ACK, then DATA.
- **DATA byte:**
  - Write `regs[ptr]`, set `wr_addr`/`wr_data`, pulse `wr_stb`, ACK.
  - Then IGNORE. Extra bytes get no ACK and no write; there is no auto-increment.
- **STOP before the DATA byte completes:** no write. The pointer keeps the REG value, which supports 2-phase write-then-read.
- **Register file:** not reset; contents are X until written. The pointer resets to 0.
- **Reset, including mid-transaction:**
  - State goes to IDLE, `siod` is released and the pointer is 0.
  - `wr_stb`=0, `wr_addr`=0, `wr_data`=0, `rd_data`=0, `busy`=0.

## Timing
- Pin-to-decision latency is `SYNC_STAGES`+1 `clk` cycles.
- `wr_stb` asserts exactly `SYNC_STAGES`+2 cycles after the 8th `sioc` rising edge of the DATA byte, for 1 cycle.
- ACK drive starts 1 cycle after the falling edge is detected, which is well inside the `sioc` low phase at ≥8× oversampling.
- `siod` output changes only while synchronized `sioc` is low, so the target can never create a false START/STOP.
- Simultaneous host read and bus write to the same address: `rd_data` returns the old value that cycle and the new value on the next read.
- Glitches shorter than `SYNC_STAGES` cycles are not filtered; the initiator must meet SCCB setup/hold at the chosen oversampling ratio.

## Configuration
- **`SCCB_TARGET_READ_EN` defined:** the read ID is accepted.
  - ACK the ID, then RD_DATA shifts out `regs[ptr]` MSB first, updating `siod` on each `sioc` falling edge (a 1 bit releases the line).
  - RD_ACK then samples the initiator's bit: NA (1) goes to IGNORE; ACK (0) also goes to IGNORE, with no burst.
- **Not defined:** the read ID is treated as a mismatch (no ACK, IGNORE), and RD_* logic is absent.

## Structure
- Shared package `sccb_pkg`: state enum, `SCCB_WRITE_BIT`/`SCCB_READ_BIT` constants, byte and bit-count widths.
- One natural sub-module, `sccb_sync_edge`: synchronizer plus rise/fall detect, instantiated once each for `sioc` and `siod`.
- Register file is inferred locally as distributed RAM or flops.

## Test plan
- **Write:** write 0x42, 0x12, 0x80 → ACK after each byte; `wr_stb` once with `wr_addr`=0x12, `wr_data`=0x80; `rd_addr`=0x12 gives 0x80.
- **Wrong ID:** ID 0x60, 0x12, 0x55 → `siod` never driven low; no `wr_stb`; `regs[0x12]` unchanged.
- **Repeated START:** 0x42, 0x3A, repeated START, 0x42, 0x40, 0xD0, STOP → single commit to 0x40 = 0xD0; 0x3A untouched.
- **Reset mid-byte:** `reset` pulse during the 5th bit of DATA → `siod`=z, `busy`=0, no `wr_stb`; the next full write commits normally.
- **Read (with `SCCB_TARGET_READ_EN`):**
  - Write 0x42, 0x0A, 0x76, STOP, then 0x42, 0x0A, STOP, then 0x43 with 8 clocks and NA.
  - Expected: 0x76 shifted out MSB first; `siod` released after RD_ACK.
- **Extra byte:** 0x42, 0x12, 0x01, 0x02 → only 0x01 is written; the 4th byte gets no ACK.
